// File: rtl/fs_seq.sv
// Multi-cycle W-bit subtractor: one shared 8-bit ripple subtractor walks the
// operand bytes LSB-first, carrying the borrow between passes.

module FS_8 (
  input  logic [7:0] x,
  input  logic [7:0] y,
  input  logic       cin,
  output logic [7:0] out,
  output logic       cout
);
  logic [8:0] brw;

  always_comb begin
    brw    = '0;
    brw[0] = cin;
    out    = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      out[i]     = x[i] ^ y[i] ^ brw[i];
      brw[i + 1] = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & brw[i]);
    end
    cout = brw[8];
  end
endmodule

module fs_seq #(
  parameter int NUM_SLICES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [8*NUM_SLICES-1:0] a,
  input  logic [8*NUM_SLICES-1:0] b,
  input  logic                    bin,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [8*NUM_SLICES-1:0] diff,
  output logic                    bout,
  output logic                    zero
);
  localparam int IW = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_SLICES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_nx;

  logic [IW-1:0]                idx;
  logic                         brw;
  logic [NUM_SLICES-1:0][7:0]   a_q;
  logic [NUM_SLICES-1:0][7:0]   b_q;
  logic [NUM_SLICES-1:0][7:0]   diff_q;
  logic                         bout_q;
  logic [7:0]                   fs_out;
  logic                         fs_cout;

  FS_8 u_fs (
    .x    (a_q[idx]),
    .y    (b_q[idx]),
    .cin  (brw),
    .out  (fs_out),
    .cout (fs_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid)      state_nx = RUN;
      RUN:     if (idx == LAST)   state_nx = DONE;
      DONE:    if (out_ready)     state_nx = IDLE;
      default:                    state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Datapath: operands are only captured in IDLE, so RUN/DONE ignore the inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx    <= '0;
      brw    <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      diff_q <= '0;
      bout_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_q <= a;
          b_q <= b;
          brw <= bin;
          idx <= '0;
        end
        RUN: begin
          diff_q[idx] <= fs_out;
          brw         <= fs_cout;
          if (idx == LAST) begin
            bout_q <= fs_cout;
            idx    <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign diff = diff_q;
  assign bout = bout_q;
  assign zero = (diff_q == '0);
endmodule

// File: tb/tb_fs_seq.sv
// Randomised self-checking bench for fs_seq against an arithmetic reference model.

module tb_fs_seq;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, bin, out_valid, out_ready, bout, zero;
  logic [31:0] a, b, diff;

  int compared   = 0;
  int mismatched = 0;

  fs_seq #(.NUM_SLICES(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bout(bout), .zero(zero)
  );

  always #5 clk = ~clk;

  // Reference: full-precision subtraction; borrow is the sign of the 33-bit result.
  function automatic logic [32:0] model(input logic [31:0] x, input logic [31:0] y,
                                        input logic c);
    logic [32:0] t;
    t = {1'b0, x} - {1'b0, y} - {32'b0, c};
    return t;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Presents one operation, scrambles inputs while busy, returns result and latency.
  task automatic run_op(input logic [31:0] xa, input logic [31:0] xb, input logic xc,
                        output logic [31:0] rd, output logic rb, output logic rz,
                        output int lat);
    in_valid = 1'b1; a = xa; b = xb; bin = xc; out_ready = 1'b0;
    lat = 0;
    do begin
      tick();
      lat++;
      in_valid = 1'($urandom_range(0, 1));
      a = $urandom; b = $urandom; bin = 1'($urandom_range(0, 1));
      out_ready = (out_valid) ? 1'b0 : 1'($urandom_range(0, 1));
    end while (!out_valid && lat < 20);
    rd = diff; rb = bout; rz = zero;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; bin = 1'b0;
    tick(); tick();
    rst = 1'b0;
    compared++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || diff !== 32'h0 || bout !== 1'b0 || zero !== 1'b1) begin
      mismatched++;
      $display("FAIL reset: in_ready=%b out_valid=%b diff=%h bout=%b zero=%b, want 1 0 00000000 0 1",
               in_ready, out_valid, diff, bout, zero);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    compared++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL idle_out_ready: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic check_op(input string name, input logic [31:0] xa, input logic [31:0] xb,
                          input logic xc);
    logic [31:0] rd; logic rb, rz; int lat; logic [32:0] m;
    m = model(xa, xb, xc);
    run_op(xa, xb, xc, rd, rb, rz, lat);
    compared++;
    if (lat !== 5) begin
      mismatched++;
      $display("FAIL %s latency: got %0d want 5", name, lat);
    end
    compared++;
    if (rd !== m[31:0] || rb !== m[32] || rz !== (m[31:0] == 32'h0)) begin
      mismatched++;
      $display("FAIL %s result: got diff=%h bout=%b zero=%b want diff=%h bout=%b zero=%b",
               name, rd, rb, rz, m[31:0], m[32], (m[31:0] == 32'h0));
    end
  endtask

  task automatic test_directed();
    check_op("small",       32'h0000_0005, 32'h0000_0003, 1'b0);
    check_op("slice_cross", 32'h0000_0100, 32'h0000_0001, 1'b0);
    check_op("underflow",   32'h0000_0000, 32'h0000_0001, 1'b0);
    check_op("equal_b0",    32'h1234_5678, 32'h1234_5678, 1'b0);
    check_op("equal_b1",    32'h1234_5678, 32'h1234_5678, 1'b1);
    check_op("max_minus",   32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
  endtask

  task automatic test_random();
    logic [31:0] xa, xb;
    for (int i = 0; i < 40; i++) begin
      xa = $urandom;
      case ($urandom_range(0, 3))
        0: xb = xa;
        1: xb = xa + 32'($urandom_range(0, 2));
        2: xb = {xa[31:8], 8'($urandom)};
        default: xb = $urandom;
      endcase
      check_op("random", xa, xb, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_hold();
    logic [32:0] m; int lat; logic bad;
    m = model(32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b1);
    in_valid = 1'b1; a = 32'hDEAD_BEEF; b = 32'hCAFE_F00D; bin = 1'b1; out_ready = 1'b0;
    lat = 0;
    do begin tick(); lat++; in_valid = 1'b0; end while (!out_valid && lat < 20);
    compared++;
    if (out_valid !== 1'b1) begin
      mismatched++;
      $display("FAIL hold_timeout: out_valid=%b want 1 within 20 cycles", out_valid);
    end
    for (int i = 0; i < 10; i++) begin
      in_valid = ~in_valid; a = $urandom; b = $urandom; bin = ~bin;
      tick();
      bad = (out_valid !== 1'b1) || (in_ready !== 1'b0) || (diff !== m[31:0]) || (bout !== m[32]);
      compared++;
      if (bad) begin
        mismatched++;
        $display("FAIL hold[%0d]: out_valid=%b in_ready=%b diff=%h bout=%b want 1 0 %h %b",
                 i, out_valid, in_ready, diff, bout, m[31:0], m[32]);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    compared++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL hold_release: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_abort();
    int seen;
    in_valid = 1'b1; a = 32'h0000_00FF; b = 32'h0000_0001; bin = 1'b0;
    tick();                 // accept
    in_valid = 1'b0;
    tick();                 // second RUN cycle now in progress
    rst = 1'b1;
    tick();
    rst = 1'b0;
    compared++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || diff !== 32'h0 || zero !== 1'b1) begin
      mismatched++;
      $display("FAIL abort_state: in_ready=%b out_valid=%b diff=%h zero=%b want 1 0 00000000 1",
               in_ready, out_valid, diff, zero);
    end
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid === 1'b1) seen++;
    end
    compared++;
    if (seen !== 0) begin
      mismatched++;
      $display("FAIL abort_no_result: out_valid cycles=%0d want 0", seen);
    end
  endtask

  task automatic test_back_to_back();
    logic [32:0] exp_q[$];
    logic [32:0] m;
    int acc_cyc[$];
    int cyc;
    out_ready = 1'b1; in_valid = 1'b1;
    a = $urandom; b = $urandom; bin = 1'($urandom_range(0, 1));
    cyc = 0;
    while (acc_cyc.size() < 3 && cyc < 40) begin
      if (in_ready === 1'b1) begin
        exp_q.push_back(model(a, b, bin));
        acc_cyc.push_back(cyc);
      end
      tick();
      cyc++;
      if (out_valid === 1'b1) begin
        m = (exp_q.size() > 0) ? exp_q.pop_front() : 33'h0;
        compared++;
        if (diff !== m[31:0] || bout !== m[32]) begin
          mismatched++;
          $display("FAIL b2b_result: diff=%h bout=%b want %h %b", diff, bout, m[31:0], m[32]);
        end
      end
      if (in_ready === 1'b1) begin
        a = $urandom; b = $urandom; bin = 1'($urandom_range(0, 1));
      end
    end
    in_valid = 1'b0;
    compared++;
    if (acc_cyc.size() != 3) begin
      mismatched++;
      $display("FAIL b2b_accepts: got %0d accepts want 3", acc_cyc.size());
    end else begin
      compared++;
      if (acc_cyc[1] - acc_cyc[0] != 6 || acc_cyc[2] - acc_cyc[1] != 6) begin
        mismatched++;
        $display("FAIL b2b_spacing: got %0d,%0d want 6,6",
                 acc_cyc[1] - acc_cyc[0], acc_cyc[2] - acc_cyc[1]);
      end
    end
    for (int i = 0; i < 8; i++) tick();
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_hold();
    test_reset_abort();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
